// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU operand/opcode sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_LOAD_A    = 3'd0,
        S_LOAD_B    = 3'd1,
        S_SELECT_OP = 3'd2,
        S_EXEC      = 3'd3,
        S_SHOW      = 3'd4
    } seq_state_t;

    localparam int NUM_OPS = 10;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_MOD = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one active-low push-button, filters bounce, and emits a
// single-cycle pulse when the filtered level goes from released to pressed.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic          settle;
    logic [CW-1:0] count;

    // The sample that completes a full run of mismatches is itself the last one counted.
    assign settle = (sync_2 != level) && (count == LAST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            press  <= settle && !sync_2;
            if (sync_2 == level) begin
                count <= '0;
            end else if (settle) begin
                level <= sync_2;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Button-driven front end for the ALU: operand/opcode entry FSM, registered
// ALU inputs, result/flag capture and the value shown on the 7-segment display.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic         btn_next_n,
    input  logic         btn_prev_n,
    input  logic         btn_enter_n,
    input  logic [N-1:0] alu_result,
    input  logic         alu_v,
    input  logic         alu_c,
    input  logic         alu_n,
    input  logic         alu_z,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic         done,
    output logic [2:0]   state_q,
    output logic [N-1:0] disp_value
);

    seq_state_t   state;
    seq_state_t   state_n;
    logic [N-1:0] a_n;
    logic [N-1:0] b_n;
    logic [3:0]   control_n;
    logic [N-1:0] result_n;
    logic [3:0]   flags_n;
    logic         done_n;
    logic         next_press;
    logic         prev_press;
    logic         enter_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_next_n),
        .press (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_prev_n),
        .press (prev_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_enter_n),
        .press (enter_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD_A;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            alu_a       <= a_n;
            alu_b       <= b_n;
            alu_control <= control_n;
            result_q    <= result_n;
            flags_q     <= flags_n;
            done        <= done_n;
        end
    end

    // Enter always takes priority in SELECT_OP; opposing next/prev cancel out.
    always_comb begin
        state_n   = state;
        a_n       = alu_a;
        b_n       = alu_b;
        control_n = alu_control;
        result_n  = result_q;
        flags_n   = flags_q;
        done_n    = 1'b0;
        case (state)
            S_LOAD_A: begin
                if (enter_press) begin
                    a_n     = sw;
                    state_n = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (enter_press) begin
                    b_n     = sw;
                    state_n = S_SELECT_OP;
                end
            end
            S_SELECT_OP: begin
                if (enter_press) begin
                    state_n = S_EXEC;
                end else if (next_press && !prev_press) begin
                    control_n = (alu_control == LAST_OP) ? 4'd0 : alu_control + 4'd1;
                end else if (prev_press && !next_press) begin
                    control_n = (alu_control == 4'd0) ? LAST_OP : alu_control - 4'd1;
                end
            end
            S_EXEC: begin
                result_n = alu_result;
                flags_n  = {alu_v, alu_c, alu_n, alu_z};
                done_n   = 1'b1;
                state_n  = S_SHOW;
            end
            S_SHOW: begin
                if (enter_press) begin
                    state_n = S_LOAD_A;
                end
            end
            default: begin
                state_n = S_LOAD_A;
            end
        endcase
    end

    always_comb begin
        case (state)
            S_SELECT_OP, S_EXEC: disp_value = N'(alu_control);
            S_SHOW:              disp_value = result_q;
            default:             disp_value = sw;
        endcase
    end

    assign state_q = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural stand-in ALU,
// directed button/debounce scenarios and randomized operand/opcode sessions.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int N        = 4;
    localparam int DEB      = 4;
    localparam int HOLD     = 10;
    localparam int GAP      = 12;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic [3:0] op;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sw;
    logic         btn_next_n;
    logic         btn_prev_n;
    logic         btn_enter_n;
    logic [N-1:0] alu_result;
    logic         alu_v;
    logic         alu_c;
    logic         alu_n;
    logic         alu_z;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic         done;
    logic [2:0]   state_q;
    logic [N-1:0] disp_value;
    logic [7:0]   alu_out;

    int compared   = 0;
    int mismatched = 0;

    exp_t       sb_q[$];
    seq_state_t m_state;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [3:0] m_op;
    logic [3:0] m_res;
    logic [3:0] m_flags;

    alu_op_sequencer #(.N(N), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .btn_next_n  (btn_next_n),
        .btn_prev_n  (btn_prev_n),
        .btn_enter_n (btn_enter_n),
        .alu_result  (alu_result),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .result_q    (result_q),
        .flags_q     (flags_q),
        .done        (done),
        .state_q     (state_q),
        .disp_value  (disp_value)
    );

    // Returns {v,c,n,z,result}; c is carry for add and no-borrow for subtract.
    function automatic logic [7:0] refAlu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op);
        int r;
        logic v, c, n;
        v = 1'b0;
        c = 1'b0;
        n = 1'b0;
        r = 0;
        case (op)
            OP_ADD: begin r = int'(a) + int'(b); c = (r > 15); end
            OP_SUB: begin r = int'(a) - int'(b); c = (a >= b); n = (a < b); end
            OP_AND: r = int'(a & b);
            OP_OR:  r = int'(a | b);
            OP_XOR: r = int'(a ^ b);
            OP_LSR: r = int'(a) >> b;
            OP_LSL: r = int'(a) << b;
            OP_MOD: if (b == 0) v = 1'b1; else r = int'(a) % int'(b);
            OP_MUL: r = int'(a) * int'(b);
            OP_DIV: if (b == 0) v = 1'b1; else r = int'(a) / int'(b);
            default: r = 0;
        endcase
        r = r & 15;
        return {v, c, n, (r == 0), 4'(r)};
    endfunction

    always_comb alu_out = refAlu(alu_a, alu_b, alu_control);
    assign {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkState(input string tag);
        int exp_disp;
        case (m_state)
            S_SELECT_OP, S_EXEC: exp_disp = int'(m_op);
            S_SHOW:              exp_disp = int'(m_res);
            default:             exp_disp = int'(sw);
        endcase
        checkOutput({tag, ".state"},   int'(state_q),     int'(m_state));
        checkOutput({tag, ".a"},       int'(alu_a),       int'(m_a));
        checkOutput({tag, ".b"},       int'(alu_b),       int'(m_b));
        checkOutput({tag, ".control"}, int'(alu_control), int'(m_op));
        checkOutput({tag, ".disp"},    int'(disp_value),  exp_disp);
    endtask

    // Model reaction to one cycle of press events, applied before the DUT sees them.
    task automatic modelPress(input logic do_next, input logic do_prev, input logic do_enter);
        logic [7:0] ref_out;
        if (do_enter) begin
            case (m_state)
                S_LOAD_A: begin m_a = sw; m_state = S_LOAD_B; end
                S_LOAD_B: begin m_b = sw; m_state = S_SELECT_OP; end
                S_SELECT_OP: begin
                    ref_out = refAlu(m_a, m_b, m_op);
                    m_res   = ref_out[3:0];
                    m_flags = ref_out[7:4];
                    sb_q.push_back('{res: m_res, flags: m_flags, op: m_op});
                    m_state = S_SHOW;
                end
                S_SHOW: m_state = S_LOAD_A;
                default: m_state = S_LOAD_A;
            endcase
        end else if (m_state == S_SELECT_OP && do_next != do_prev) begin
            if (do_next) m_op = 4'((int'(m_op) + 1) % NUM_OPS);
            else         m_op = 4'((int'(m_op) + NUM_OPS - 1) % NUM_OPS);
        end
    endtask

    task automatic applyStimulus(input logic do_next, input logic do_prev, input logic do_enter,
                                 input string tag);
        modelPress(do_next, do_prev, do_enter);
        @(negedge clk);
        btn_next_n  = !do_next;
        btn_prev_n  = !do_prev;
        btn_enter_n = !do_enter;
        repeat (HOLD) @(negedge clk);
        btn_next_n  = 1'b1;
        btn_prev_n  = 1'b1;
        btn_enter_n = 1'b1;
        repeat (GAP) @(negedge clk);
        checkState(tag);
    endtask

    task automatic setSwitches(input logic [3:0] value);
        @(negedge clk);
        sw = value;
    endtask

    task automatic resetModel();
        m_state = S_LOAD_A;
        m_a     = 4'd0;
        m_b     = 4'd0;
        m_op    = 4'd0;
        m_res   = 4'd0;
        m_flags = 4'd0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".state"},   int'(state_q),     int'(S_LOAD_A));
        checkOutput({tag, ".a"},       int'(alu_a),       0);
        checkOutput({tag, ".b"},       int'(alu_b),       0);
        checkOutput({tag, ".control"}, int'(alu_control), 0);
        checkOutput({tag, ".result"},  int'(result_q),    0);
        checkOutput({tag, ".flags"},   int'(flags_q),     0);
        checkOutput({tag, ".done"},    int'(done),        0);
        checkOutput({tag, ".disp"},    int'(disp_value),  0);
    endtask

    // Monitor: every done pulse retires one scoreboard entry and must last one cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb.unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb.result",  int'(result_q),    int'(e.res));
                    checkOutput("sb.flags",   int'(flags_q),     int'(e.flags));
                    checkOutput("sb.control", int'(alu_control), int'(e.op));
                    checkOutput("sb.disp",    int'(disp_value),  int'(e.res));
                    checkOutput("sb.state",   int'(state_q),     int'(S_SHOW));
                end
                @(negedge clk);
                checkOutput("sb.done_width", int'(done), 0);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        sw          = '0;
        btn_next_n  = 1'b1;
        btn_prev_n  = 1'b1;
        btn_enter_n = 1'b1;
        resetModel();
        #2;
        checkResetValues("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("por_release.state", int'(state_q), int'(S_LOAD_A));

        // Reach SELECT_OP with opcode 7, then pull reset between clock edges.
        setSwitches(4'd6);
        applyStimulus(1'b0, 1'b0, 1'b1, "rst.loada");
        setSwitches(4'd11);
        applyStimulus(1'b0, 1'b0, 1'b1, "rst.loadb");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, "rst.next");
        checkOutput("rst.pre_control", int'(alu_control), 7);
        @(negedge clk);
        sw = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("rst_mid");
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_release.state", int'(state_q), int'(S_LOAD_A));

        // Add 3 + 5.
        setSwitches(4'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, "add.loada");
        setSwitches(4'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, "add.loadb");
        applyStimulus(1'b0, 1'b0, 1'b1, "add.exec");
        checkOutput("add.control", int'(alu_control), 0);
        checkOutput("add.result",  int'(result_q),    8);
        checkOutput("add.flags",   int'(flags_q),     0);
        checkOutput("add.disp",    int'(disp_value),  8);

        // Subtract 5 - 5: opcode retained from add, one next step.
        applyStimulus(1'b0, 1'b0, 1'b1, "sub.show");
        applyStimulus(1'b0, 1'b0, 1'b1, "sub.loada");
        applyStimulus(1'b0, 1'b0, 1'b1, "sub.loadb");
        applyStimulus(1'b1, 1'b0, 1'b0, "sub.next");
        applyStimulus(1'b0, 1'b0, 1'b1, "sub.exec");
        checkOutput("sub.control", int'(alu_control), 1);
        checkOutput("sub.result",  int'(result_q),    0);
        checkOutput("sub.flags",   int'(flags_q),     5);

        // Opcode wrap-around and cancelling presses.
        applyStimulus(1'b0, 1'b0, 1'b1, "wrap.show");
        setSwitches(4'd9);
        applyStimulus(1'b0, 1'b0, 1'b1, "wrap.loada");
        setSwitches(4'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, "wrap.loadb");
        applyStimulus(1'b0, 1'b1, 1'b0, "wrap.prev1");
        checkOutput("wrap.at0", int'(alu_control), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, "wrap.prev0");
        checkOutput("wrap.prev_from0", int'(alu_control), 9);
        applyStimulus(1'b1, 1'b0, 1'b0, "wrap.next9");
        checkOutput("wrap.next_from9", int'(alu_control), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, "wrap.both");
        checkOutput("wrap.both", int'(alu_control), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, "wrap.exec");
        applyStimulus(1'b0, 1'b0, 1'b1, "wrap.show2");
        applyStimulus(1'b1, 1'b0, 1'b0, "wrap.next_in_loada");
        setSwitches(4'($urandom_range(0, 15)));
        applyStimulus(1'b0, 1'b0, 1'b1, "deb.loada");
        setSwitches(4'($urandom_range(0, 15)));
        applyStimulus(1'b0, 1'b0, 1'b1, "deb.loadb");

        // Three-cycle low glitch must not register.
        @(negedge clk);
        btn_next_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_next_n = 1'b1;
        repeat (GAP) @(negedge clk);
        checkState("deb.glitch");

        // Long hold: exactly one step, taking effect on the edge after the pulse.
        @(negedge clk);
        btn_next_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("deb.before_step", int'(alu_control), int'(m_op));
        modelPress(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("deb.step_edge", int'(alu_control), int'(m_op));
        repeat (13) @(negedge clk);
        btn_next_n = 1'b1;
        repeat (GAP) @(negedge clk);
        checkState("deb.hold");

        // Bounce 1-0-1-0 then hold: still one step.
        modelPress(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        btn_next_n = 1'b0;
        @(negedge clk);
        btn_next_n = 1'b1;
        @(negedge clk);
        btn_next_n = 1'b0;
        repeat (20) @(negedge clk);
        btn_next_n = 1'b1;
        repeat (GAP) @(negedge clk);
        checkState("deb.bounce");
        checkOutput("deb.control2", int'(alu_control), 2);

        // Enter together with next at opcode 2 (AND): enter wins.
        applyStimulus(1'b1, 1'b0, 1'b1, "and.enter_next");
        checkOutput("and.control", int'(alu_control), 2);
        checkOutput("and.result",  int'(result_q),    int'(m_a & m_b));

        // Randomized sessions.
        for (int t = 0; t < 12; t++) begin
            int steps;
            int kind;
            applyStimulus(1'b0, 1'b0, 1'b1, "rnd.show");
            setSwitches(4'($urandom_range(0, 15)));
            applyStimulus(1'b0, 1'b0, 1'b1, "rnd.loada");
            setSwitches(4'($urandom_range(0, 15)));
            applyStimulus(1'b0, 1'b0, 1'b1, "rnd.loadb");
            steps = int'($urandom_range(0, 5));
            for (int s = 0; s < steps; s++) begin
                kind = int'($urandom_range(0, 2));
                applyStimulus(kind != 1, kind != 0, 1'b0, "rnd.select");
            end
            applyStimulus(1'b0, 1'b0, 1'b1, "rnd.exec");
        end

        repeat (4) @(negedge clk);
        checkOutput("sb.drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
